// File: rtl/pika_pkg.sv
// Shared constants and types for the pika volleyball datapath.
//
// Holds the screen, floor and net geometry, the sprite size, the vertical
// fixed-point format, and the player state enum. The player and ball blocks
// both import this package, so these values are defined only here.
package pika_pkg;

    // Screen / court geometry, in pixels
    localparam int SCREEN_W    = 320;
    localparam int PIKA_W      = 64;
    localparam int PIKA_H      = 64;
    localparam int FLOOR_Y     = 240;
    localparam int NET_LEFT_X  = 154;
    localparam int NET_RIGHT_X = 166;

    // Vertical position is 10.6 unsigned fixed point
    localparam int FRAC_W   = 6;
    localparam int POS_W    = 10;
    localparam int POS_FX_W = POS_W + FRAC_W;
    localparam int VEL_W    = 10;

    // Sprite top y when standing on the floor
    localparam int GROUND_Y = FLOOR_Y - PIKA_H;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        SMASH  = 2'd2
    } pika_state_e;

    // Clamp an 11-bit signed candidate x into [lo, hi] and return it as a
    // 10-bit pixel coordinate. lo and hi are always non-negative.
    function automatic logic [POS_W-1:0] clamp_x(
        input logic signed [POS_W:0] x,
        input logic signed [POS_W:0] lo,
        input logic signed [POS_W:0] hi
    );
        logic signed [POS_W:0] r;
        if (x < lo)
            r = lo;
        else if (x > hi)
            r = hi;
        else
            r = x;
        return r[POS_W-1:0];
    endfunction

endpackage

// File: rtl/player_vert_integrator.sv
// Vertical kinematics for one player sprite.
//
// Owns the fixed-point y position and the signed vertical velocity. On each
// tick while airborne it adds velocity to position, then gravity to velocity,
// detecting landing (floor) and clamping at the ceiling. On the ground it
// holds the floor position and loads the launch velocity when asked.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - return to floor, zero velocity (round restart)
//   tick      - frame tick; state only advances on this cycle
//   launch    - while on the ground, load the jump velocity this tick
//   active    - player is airborne (JUMP or SMASH)
//   pos_y     - integer part of the y position, pixels (registered)
//   landed    - combinational pulse: this tick's update reaches the floor
module player_vert_integrator
    import pika_pkg::*;
#(
    parameter int JUMP_VEL = -384,
    parameter int GRAVITY  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic             launch,
    input  logic             active,
    output logic [POS_W-1:0] pos_y,
    output logic             landed
);

    localparam logic [POS_FX_W-1:0]        GROUND_FX   = POS_FX_W'(GROUND_Y << FRAC_W);
    localparam logic signed [POS_FX_W:0]   GROUND_FX_S = (POS_FX_W+1)'(GROUND_Y << FRAC_W);
    localparam logic signed [VEL_W-1:0]    JUMP_VEL_S  = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0]    GRAVITY_S   = VEL_W'(GRAVITY);

    logic [POS_FX_W-1:0]        pos_y_fx;
    logic signed [VEL_W-1:0]    vel_y;
    logic signed [POS_FX_W:0]   sum;

    // One extra bit so an upward move past the ceiling shows up as negative
    assign sum = $signed({1'b0, pos_y_fx})
               + $signed({{(POS_FX_W+1-VEL_W){vel_y[VEL_W-1]}}, vel_y});

    assign landed = tick && active && (sum >= GROUND_FX_S);
    assign pos_y  = pos_y_fx[POS_FX_W-1:FRAC_W];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos_y_fx <= GROUND_FX;
            vel_y    <= '0;
        end else if (tick) begin
            if (!active) begin
                // Motion starts on the tick after launch
                pos_y_fx <= GROUND_FX;
                vel_y    <= launch ? JUMP_VEL_S : '0;
            end else if (sum >= GROUND_FX_S) begin
                pos_y_fx <= GROUND_FX;
                vel_y    <= '0;
            end else if (sum < 0) begin
                pos_y_fx <= '0;
                vel_y    <= vel_y + GRAVITY_S;
            end else begin
                pos_y_fx <= sum[POS_FX_W-1:0];
                vel_y    <= vel_y + GRAVITY_S;
            end
        end
    end

endmodule

// File: rtl/player_motion.sv
// Per-player kinematics: turns move/jump/smash controls into the sprite
// top-left position and the smash flag consumed by ball physics.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   frame_tick      - one-cycle pulse; state advances only on these cycles
//   round_reset     - return to spawn on any cycle (priority over all else)
//   op_move_left/right, op_jump, op_smash - level controls
//   pos_x_o, pos_y_o - sprite left x / top y, pixels (registered)
//   is_smash        - smash window active (registered)
//   airborne        - player is not on the ground (registered)
module player_motion
    import pika_pkg::*;
#(
    parameter int SIDE         = 0,
    parameter int MOVE_SPEED   = 2,
    parameter int JUMP_VEL     = -384,
    parameter int GRAVITY      = 16,
    parameter int SMASH_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             round_reset,
    input  logic             op_move_left,
    input  logic             op_move_right,
    input  logic             op_jump,
    input  logic             op_smash,
    output logic [POS_W-1:0] pos_x_o,
    output logic [POS_W-1:0] pos_y_o,
    output logic             is_smash,
    output logic             airborne
);

    localparam int X_MIN   = (SIDE == 0) ? 0  : NET_RIGHT_X;
    localparam int X_MAX   = (SIDE == 0) ? NET_LEFT_X - PIKA_W : SCREEN_W - PIKA_W;
    localparam int SPAWN_X = (SIDE == 0) ? 26 : 230;

    localparam logic signed [POS_W:0]   X_MIN_S = (POS_W+1)'(X_MIN);
    localparam logic signed [POS_W:0]   X_MAX_S = (POS_W+1)'(X_MAX);
    localparam logic signed [POS_W:0]   SPEED_S = (POS_W+1)'(MOVE_SPEED);
    localparam logic [POS_W-1:0]        SPAWN_X_U = POS_W'(SPAWN_X);
    localparam logic [3:0]              SMASH_LEN = 4'(SMASH_FRAMES);

    pika_state_e              state;
    logic [3:0]               smash_cnt;
    logic                     smash_used;
    logic                     landed;
    logic signed [POS_W:0]    x_step;
    logic [POS_W-1:0]         x_next;

    // Horizontal step at 11-bit signed width so moving left from 0 goes
    // negative instead of wrapping, then gets clamped
    always_comb begin
        x_step = $signed({1'b0, pos_x_o});
        if (op_move_left && !op_move_right)
            x_step = x_step - SPEED_S;
        else if (op_move_right && !op_move_left)
            x_step = x_step + SPEED_S;
        x_next = clamp_x(x_step, X_MIN_S, X_MAX_S);
    end

    player_vert_integrator #(
        .JUMP_VEL (JUMP_VEL),
        .GRAVITY  (GRAVITY)
    ) u_vert (
        .clk    (clk),
        .rst    (rst),
        .clear  (round_reset),
        .tick   (frame_tick),
        .launch (op_jump),
        .active (state != GROUND),
        .pos_y  (pos_y_o),
        .landed (landed)
    );

    always_ff @(posedge clk) begin
        if (rst || round_reset) begin
            state      <= GROUND;
            pos_x_o    <= SPAWN_X_U;
            smash_cnt  <= '0;
            smash_used <= 1'b0;
            is_smash   <= 1'b0;
            airborne   <= 1'b0;
        end else if (frame_tick) begin
            pos_x_o <= x_next;
            unique case (state)
                GROUND: begin
                    if (op_jump) begin
                        state      <= JUMP;
                        smash_used <= 1'b0;
                        airborne   <= 1'b1;
                    end
                end
                JUMP: begin
                    // Landing wins over a smash request on the same tick
                    if (landed) begin
                        state     <= GROUND;
                        airborne  <= 1'b0;
                        is_smash  <= 1'b0;
                        smash_cnt <= '0;
                    end else if (op_smash && !smash_used) begin
                        state      <= SMASH;
                        smash_used <= 1'b1;
                        smash_cnt  <= SMASH_LEN;
                        is_smash   <= 1'b1;
                    end
                end
                SMASH: begin
                    if (landed) begin
                        state     <= GROUND;
                        airborne  <= 1'b0;
                        is_smash  <= 1'b0;
                        smash_cnt <= '0;
                    end else begin
                        smash_cnt <= smash_cnt - 4'd1;
                        if (smash_cnt == 4'd1) begin
                            state    <= JUMP;
                            is_smash <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= GROUND;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: both court sides share one set of
// controls; expected positions come from hand-derived closed forms.
module tb_player_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       round_reset = 1'b0;
    logic       ml = 1'b0;
    logic       mr = 1'b0;
    logic       jp = 1'b0;
    logic       sm = 1'b0;
    logic [9:0] x1, y1, x2, y2;
    logic       s1, a1, s2, a2;
    int         tests = 0;
    int         fails = 0;
    int         highs;

    always #5 clk = ~clk;

    player_motion #(.SIDE(0)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_reset(round_reset),
        .op_move_left(ml), .op_move_right(mr), .op_jump(jp), .op_smash(sm),
        .pos_x_o(x1), .pos_y_o(y1), .is_smash(s1), .airborne(a1)
    );

    player_motion #(.SIDE(1)) dut2 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_reset(round_reset),
        .op_move_left(ml), .op_move_right(mr), .op_jump(jp), .op_smash(sm),
        .pos_x_o(x2), .pos_y_o(y2), .is_smash(s2), .airborne(a2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; outputs are sampled on the following falling edge
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic pulse_round_reset();
        @(negedge clk) round_reset = 1'b1;
        @(negedge clk) round_reset = 1'b0;
    endtask

    // y after k airborne ticks from the floor: 11264 - 384k + 8k(k-1), /64
    function automatic int y_model(input int k);
        return (11264 - 384 * k + 8 * k * (k - 1)) / 64;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("rst_x1", int'(x1), 26);
        check("rst_y1", int'(y1), 176);
        check("rst_smash1", int'(s1), 0);
        check("rst_air1", int'(a1), 0);
        check("rst_x2", int'(x2), 230);
        check("rst_y2", int'(y2), 176);

        // Idle ticks leave everything unchanged
        repeat (3) tick();
        check("idle_x1", int'(x1), 26);
        check("idle_y1", int'(y1), 176);
        check("idle_air1", int'(a1), 0);

        // Left held 20 ticks: P1 clamps at 0 on tick 13; P2 walks toward 166
        ml = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("left_x1", int'(x1), imax(26 - 2 * k, 0));
            check("left_x2", int'(x2), imax(230 - 2 * k, 166));
        end
        // Both held: no motion
        mr = 1'b1;
        repeat (3) tick();
        check("both_x1", int'(x1), 0);
        check("both_x2", int'(x2), 190);
        ml = 1'b0;
        mr = 1'b0;

        // round_reset without frame_tick
        pulse_round_reset();
        check("rr_x1", int'(x1), 26);
        check("rr_x2", int'(x2), 230);

        // Right held 20 ticks: P2 clamps at 256 on tick 13
        mr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("right_x1", int'(x1), imin(26 + 2 * k, 90));
            check("right_x2", int'(x2), imin(230 + 2 * k, 256));
        end
        mr = 1'b0;

        // Left held 40 ticks from spawn: P2 clamps at 166 on tick 32
        pulse_round_reset();
        ml = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("left2_x2", int'(x2), imax(230 - 2 * k, 166));
        end
        check("left2_x1", int'(x1), 0);
        ml = 1'b0;
        pulse_round_reset();

        // Plain jump: apex 101 at tick 24, landing at tick 49
        jp = 1'b1;
        tick();
        jp = 1'b0;
        check("jump0_air", int'(a1), 1);
        check("jump0_y", int'(y1), 176);
        for (int k = 1; k <= 49; k++) begin
            tick();
            check("jump_y1", int'(y1), (k == 49) ? 176 : y_model(k));
            check("jump_air1", int'(a1), (k < 49) ? 1 : 0);
            check("jump_y2", int'(y2), (k == 49) ? 176 : y_model(k));
        end
        check("apex_ref", y_model(24), 101);

        // Jump with smash held from tick 5: exactly 8 ticks of is_smash
        highs = 0;
        jp = 1'b1;
        tick();
        jp = 1'b0;
        for (int k = 1; k <= 49; k++) begin
            if (k == 5) sm = 1'b1;
            tick();
            if (s1) highs++;
            check("smash_flag", int'(s1), (k >= 5 && k <= 12) ? 1 : 0);
            check("smash_air", int'(a1), (k < 49) ? 1 : 0);
            if (k == 49) check("smash_land_y", int'(y1), 176);
        end
        sm = 1'b0;
        check("smash_count", highs, 8);

        // round_reset mid-SMASH at y=120, no frame_tick
        jp = 1'b1;
        ml = 1'b1;
        tick();
        jp = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 10) sm = 1'b1;
            tick();
        end
        sm = 1'b0;
        ml = 1'b0;
        check("mid_smash", int'(s1), 1);
        check("mid_y", int'(y1), 120);
        check("mid_x", int'(x1), 0);
        pulse_round_reset();
        check("rrs_x1", int'(x1), 26);
        check("rrs_y1", int'(y1), 176);
        check("rrs_smash", int'(s1), 0);
        check("rrs_air", int'(a1), 0);

        // Reset mid-jump behaves the same
        jp = 1'b1;
        mr = 1'b1;
        tick();
        jp = 1'b0;
        repeat (6) tick();
        mr = 1'b0;
        check("pre_rst_x1", int'(x1), 40);
        check("pre_rst_y1", int'(y1), y_model(6));
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("rstj_x1", int'(x1), 26);
        check("rstj_y1", int'(y1), 176);
        check("rstj_air", int'(a1), 0);
        check("rstj_smash", int'(s1), 0);

        // After reset the player can jump again
        jp = 1'b1;
        tick();
        jp = 1'b0;
        tick();
        check("rejump_y1", int'(y1), 170);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
